// File: rtl/fifo_interface_buffer_if.sv
// FIFOInterface handshake bundle: data word, enable (valid) and ready.
// The producer drives through master; the consumer side uses slave.
interface fifo_interface_buffer_if #(
    parameter int unsigned num_bits = 16
) ();
    logic [num_bits-1:0] data;
    logic                enable;
    logic                ready;

    modport master (output data, output enable, input ready);
    modport slave  (input data, input enable, output ready);
endinterface

// File: rtl/fifo_interface_buffer.sv
// Single-clock first-word-fall-through FIFO with FIFOInterface handshakes on both sides.
// Optional occupancy output enabled by defining FIFO_INTERFACE_BUFFER_COUNT_EN.
module fifo_interface_buffer #(
    parameter int unsigned num_bits = 16,
    parameter int unsigned depth    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    fifo_interface_buffer_if.slave        in_if,
    fifo_interface_buffer_if.master       out_if,
    output logic                          empty,
    output logic                          full
`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
    ,
    output logic [$clog2(depth):0]        count
`endif
);
    localparam int unsigned addr_w = $clog2(depth);
    localparam int unsigned ptr_w  = addr_w + 1;

    logic [num_bits-1:0] mem [depth];
    logic [ptr_w-1:0]    wr_ptr;
    logic [ptr_w-1:0]    rd_ptr;
    logic                active;
    logic                wr_en;
    logic                rd_en;

    assign wr_en = in_if.enable && in_if.ready;
    assign rd_en = out_if.enable && out_if.ready;

    // Pointer MSB is a wrap bit so equal low bits distinguish empty from full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]) &&
                   (wr_ptr[addr_w] != rd_ptr[addr_w]);

    // Ready only rises on the first edge after reset release.
    assign in_if.ready   = active && !full;
    assign out_if.enable = !empty;
    assign out_if.data   = mem[rd_ptr[addr_w-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + ptr_w'(1);
            if (rd_en) rd_ptr <= rd_ptr + ptr_w'(1);
        end
    end

    // Storage array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[addr_w-1:0]] <= in_if.data;
    end

`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
    assign count = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_fifo_interface_buffer.sv
// Self-checking bench for fifo_interface_buffer: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fifo_interface_buffer;
    localparam int unsigned W = 16;
    localparam int unsigned D = 16;

    logic clk;
    logic reset;
    logic empty;
    logic full;
`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
    logic [$clog2(D):0] count;
`endif

    fifo_interface_buffer_if #(.num_bits(W)) in_bus ();
    fifo_interface_buffer_if #(.num_bits(W)) out_bus ();

    fifo_interface_buffer #(.num_bits(W), .depth(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_if  (in_bus),
        .out_if (out_bus),
        .empty  (empty),
        .full   (full)
`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
        ,
        .count  (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          en;
        logic [W-1:0]  data;
        logic          rdy;
        logic          exp_in_ready;
        logic          exp_out_enable;
        logic          exp_empty;
        logic          exp_full;
        logic [W-1:0]  exp_data;
    } vec_t;

    vec_t vecs [9];
    logic [W-1:0] model_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [W-1:0] d, input logic rdy);
        in_bus.enable = en;
        in_bus.data   = d;
        out_bus.ready = rdy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int next_wr;
        logic full_seen;
        logic accept;

        vecs[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111};
        vecs[1] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111};
        vecs[2] = '{1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2222};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 16'h4444, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4444};
        vecs[6] = '{1'b0, 16'h9999, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4444};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};

        // Reset held with a word offered: nothing accepted.
        reset = 1'b0;
        drive(1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_in_ready", 32'(in_bus.ready), 32'd0);
            chk("rst_out_enable", 32'(out_bus.enable), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_full", 32'(full), 32'd0);
        end
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        chk("rel_in_ready", 32'(in_bus.ready), 32'd1);
        chk("rel_empty", 32'(empty), 32'd1);

        // Vector table from empty.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].en, vecs[i].data, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d_in_ready", i), 32'(in_bus.ready), 32'(vecs[i].exp_in_ready));
            chk($sformatf("vec%0d_out_enable", i), 32'(out_bus.enable), 32'(vecs[i].exp_out_enable));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            if (vecs[i].exp_out_enable)
                chk($sformatf("vec%0d_data", i), 32'(out_bus.data), 32'(vecs[i].exp_data));
        end

        // Single word.
        drive(1'b1, 16'h1234, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        chk("single_oe", 32'(out_bus.enable), 32'd1);
        chk("single_data", 32'(out_bus.data), 32'h1234);
        out_bus.ready = 1'b1;
        step();
        out_bus.ready = 1'b0;
        chk("single_empty", 32'(empty), 32'd1);

        // Fill to full, reject a 17th word, drain in order.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, W'(k), 1'b0);
            step();
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_bus.ready), 32'd0);
`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
        chk("fill_count", 32'(count), 32'd16);
`endif
        drive(1'b1, 16'hDEAD, 1'b0);
        step();
        chk("extra_full", 32'(full), 32'd1);
        chk("extra_head", 32'(out_bus.data), 32'h0000);
        drive(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d_oe", k), 32'(out_bus.enable), 32'd1);
            chk($sformatf("drain%0d_data", k), 32'(out_bus.data), 32'(k));
            step();
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Full with simultaneous offer and read: read only.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, W'(k + 16), 1'b0);
            step();
        end
        chk("refill_full", 32'(full), 32'd1);
        drive(1'b1, 16'hAAAA, 1'b1);
        step();
        chk("fullrd_full", 32'(full), 32'd0);
        chk("fullrd_in_ready", 32'(in_bus.ready), 32'd1);
        chk("fullrd_head", 32'(out_bus.data), 32'h0011);
`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
        chk("fullrd_count", 32'(count), 32'd15);
`endif
        out_bus.ready = 1'b0;
        step();
        chk("aaaa_full", 32'(full), 32'd1);
        drive(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain2_%0d", k), 32'(out_bus.data), (k == 15) ? 32'hAAAA : 32'(k + 17));
            step();
        end
        chk("drain2_empty", 32'(empty), 32'd1);

        // Streaming 100 words with both sides always active.
        got = 0;
        next_wr = 0;
        full_seen = 1'b0;
        for (int c = 0; c < 400 && got < 100; c++) begin
            drive(next_wr < 100, W'(next_wr), 1'b1);
            accept = in_bus.enable && in_bus.ready;
            if (full) full_seen = 1'b1;
            if (out_bus.enable) begin
                chk($sformatf("stream%0d", got), 32'(out_bus.data), 32'(got));
                got++;
            end
            step();
            if (accept) next_wr++;
        end
        chk("stream_count", 32'(got), 32'd100);
        chk("stream_never_full", 32'(full_seen), 32'd0);
        drive(1'b0, 16'h0000, 1'b0);
        step();
        chk("stream_empty", 32'(empty), 32'd1);

        // Mid-operation reset discards contents.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, W'(16'h0700 + k), 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0);
        chk("mid_oe_before", 32'(out_bus.enable), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_oe", 32'(out_bus.enable), 32'd0);
        chk("mid_in_ready", 32'(in_bus.ready), 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("mid_rel_in_ready", 32'(in_bus.ready), 32'd1);
        chk("mid_rel_oe", 32'(out_bus.enable), 32'd0);
        drive(1'b1, 16'h5555, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b1);
        chk("mid_first_word", 32'(out_bus.data), 32'h5555);
        step();
        out_bus.ready = 1'b0;
        chk("mid_drained", 32'(empty), 32'd1);

        // Randomized traffic against a queue model of occupancy and order.
        model_q.delete();
        for (int i = 0; i < 2000; i++) begin
            logic m_ready;
            logic m_oe;
            m_ready = model_q.size() < D;
            m_oe    = model_q.size() != 0;
            chk("rnd_in_ready", 32'(in_bus.ready), 32'(m_ready));
            chk("rnd_out_enable", 32'(out_bus.enable), 32'(m_oe));
            chk("rnd_empty", 32'(empty), 32'(model_q.size() == 0));
            chk("rnd_full", 32'(full), 32'(model_q.size() == D));
`ifdef FIFO_INTERFACE_BUFFER_COUNT_EN
            chk("rnd_count", 32'(count), 32'(model_q.size()));
`endif
            if (m_oe) chk("rnd_data", 32'(out_bus.data), 32'(model_q[0]));
            // Phase-varying bias so the queue visits both empty and full.
            if ((i / 250) % 2 == 0)
                drive(($urandom % 4) != 0, W'($urandom), ($urandom % 4) == 0);
            else
                drive(($urandom % 4) == 0, W'($urandom), ($urandom % 4) != 0);
            if (out_bus.ready && m_oe) void'(model_q.pop_front());
            if (in_bus.enable && m_ready) model_q.push_back(in_bus.data);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_interface_buffer.md
Name: fifo_interface_buffer

Overview:
- Single-clock, first-word-fall-through FIFO whose input and output sides both use the FIFOInterface handshake (data / enable / ready).
- Inserted between FIFOInterface producers and consumers in the same ClockReset domain (e.g. host_in/host_out, mem_cmd/mem_write/mem_read paths) to decouple bursts and break ready timing paths.
- Purely synchronous storage; no clock-domain crossing.

Parameters:
- num_bits, 16, width of each data word.
- depth, 16, number of storage entries; power of two, minimum 2.

Ports:
- clk  input  1  ClockReset clock; all state updates on rising edge.
- reset  input  1  ClockReset reset; asynchronous assert, active-low (0 = in reset); deassertion synchronous to clk by the system.
- in_data  input  num_bits  write word from producer.
- in_enable  input  1  producer has a valid word on in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- out_data  output  num_bits  word at FIFO head.
- out_enable  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the head word this cycle.
- empty  output  1  no words stored.
- full  output  1  depth words stored.

Behaviour:
- Write transfer occurs on a rising edge when in_enable && in_ready.
- Read transfer occurs on a rising edge when out_enable && out_ready.
- Pointers: write and read pointers each log2(depth)+1 bits wide; the MSB is a wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers increment modulo 2*depth on their transfer.
- in_ready = !full and reset deasserted. A word is never accepted while full, even if a read happens in the same cycle (no pass-through when full).
- out_enable = !empty. out_data = mem[read pointer low bits], combinational from the RAM array (distributed-RAM style).
- out_data is don't-care when out_enable = 0; the bench must not check it then.
- Latency:
  - A word written at edge N is visible on out_data/out_enable after edge N (one cycle write-to-read).
  - A word written into an empty FIFO is never presented in the same cycle it is written.
- Simultaneous write and read when 0 < occupancy < depth: both transfers occur and occupancy is unchanged.
- Simultaneous in_enable and out_ready when empty: the write is accepted, no read occurs, occupancy becomes 1.
- Ordering: strict FIFO; words leave in arrival order with no loss or duplication.
- Holding rules:
  - in_enable without in_ready causes no state change; the producer must hold in_data.
  - out_ready without out_enable is ignored.
  - out_data and out_enable stay stable until a read transfer occurs.
- Reset (reset = 0), asynchronous and immediate:
  - Both pointers are 0.
  - empty = 1, full = 0, out_enable = 0, in_ready = 0.
  - The memory array is not reset.
- Reset asserted mid-operation discards all stored words. After the first rising edge with reset = 1, in_ready = 1 and out_enable = 0.

Optional Feature:
- Macro FIFO_INTERFACE_BUFFER_COUNT_EN.
- Defined: adds output port count, width log2(depth)+1, equal to current occupancy (write pointer minus read pointer, modulo 2*depth).
  - count is 0 in reset.
  - count updates on the same edge as the pointers and ranges 0..depth.
- Undefined: the count port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 5 cycles with in_enable=1, in_data=16'hBEEF → in_ready=0, out_enable=0, empty=1, full=0 throughout. Release reset; after the first edge, in_ready=1.
- Single word: write 16'h1234 at edge N with out_ready=0 → out_enable=1 and out_data=16'h1234 after edge N. Assert out_ready=1 for one cycle → empty=1 after the next edge.
- Fill/full (depth=16): write 16'h0000..16'h000F with out_ready=0 → full=1 and in_ready=0 after the 16th write. A 17th word 16'hDEAD offered with in_enable=1 is not stored. Drain with out_ready=1 → reads 0x0000..0x000F in order, then empty=1.
- Full with simultaneous read: at full, assert in_enable=1 (16'hAAAA) and out_ready=1 in the same cycle → only the read occurs, occupancy becomes 15, and 16'hAAAA is accepted on the next cycle.
- Wrap-around streaming: continuous in_enable=1/out_ready=1 for 100 words of incrementing data starting at 0 → output sequence 0..99 with no gaps after the first-word latency, pointers wrapping past depth, full never asserted.
- Mid-operation reset: with 7 words stored, pulse reset=0 for 1 cycle → empty=1 immediately. After release, a new write of 16'h5555 is the first word read out.
